// File: rtl/axis_i2s_transmitter_if.sv
// AXI-Stream sample bus feeding the I2S transmitter: left/right words, last marks the right word.
interface axis_i2s_transmitter_if #(
  parameter int unsigned DATA_WIDTH = 12
) ();

  logic [DATA_WIDTH-1:0] s_axis_data;
  logic                  s_axis_valid;
  logic                  s_axis_ready;
  logic                  s_axis_last;

  modport master (
    output s_axis_data,
    output s_axis_valid,
    output s_axis_last,
    input  s_axis_ready
  );

  modport slave (
    input  s_axis_data,
    input  s_axis_valid,
    input  s_axis_last,
    output s_axis_ready
  );

endinterface

// File: rtl/axis_i2s_transmitter.sv
// AXI-Stream to I2S transmitter: one stereo packet per 1024-clk frame, MCLK/SCLK/LRCK from a counter.
// Define AXIS_I2S_TX_UNDERRUN_REPEAT_EN to repeat the previous samples on underrun instead of zero.
module axis_i2s_transmitter #(
  parameter int unsigned DATA_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   resetn,
  axis_i2s_transmitter_if.slave  axis,
  output logic                   tx_mclk,
  output logic                   tx_sclk,
  output logic                   tx_lrck,
  output logic                   tx_sdout,
  output logic                   underrun
);

  logic [9:0]            cnt_q;
  logic [9:0]            cnt_next;
  logic [DATA_WIDTH-1:0] hold_l_q;
  logic [DATA_WIDTH-1:0] hold_r_q;
  logic [DATA_WIDTH-1:0] tx_l_q;
  logic [DATA_WIDTH-1:0] tx_r_q;
  logic [DATA_WIDTH-1:0] sample;
  logic                  full_q;
  logic                  ready_q;
  logic                  sdout_q;
  logic                  underrun_q;
  logic                  sdout_bit;
  logic                  frame_start;
  logic                  accept;

  assign cnt_next    = cnt_q + 10'd1;
  assign frame_start = &cnt_q;
  assign accept      = axis.s_axis_valid & ready_q;

  // Serial bit for the slot the counter is about to enter; b = 0 and b > DATA_WIDTH stay 0.
  always_comb begin
    sdout_bit = 1'b0;
    sample    = cnt_next[9] ? tx_r_q : tx_l_q;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (32'(cnt_next[8:4]) == DATA_WIDTH - i) begin
        sdout_bit = sample[i];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q      <= '0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      tx_l_q     <= '0;
      tx_r_q     <= '0;
      full_q     <= 1'b0;
      ready_q    <= 1'b0;
      sdout_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_next;
      underrun_q <= 1'b0;
      // Ready returns one edge after full clears, i.e. the edge after the frame-start load.
      ready_q    <= !full_q;

      if (cnt_q[3:0] == 4'hF) begin
        sdout_q <= sdout_bit;
      end

      if (frame_start) begin
        if (full_q) begin
          tx_l_q   <= hold_l_q;
          tx_r_q   <= hold_r_q;
          hold_l_q <= '0;
          hold_r_q <= '0;
          full_q   <= 1'b0;
        end else begin
          underrun_q <= 1'b1;
`ifdef AXIS_I2S_TX_UNDERRUN_REPEAT_EN
          tx_l_q <= tx_l_q;
          tx_r_q <= tx_r_q;
`else
          tx_l_q <= '0;
          tx_r_q <= '0;
`endif
        end
      end

      // ready_q implies full_q == 0, so an accept never collides with the load branch.
      if (accept) begin
        if (axis.s_axis_last) begin
          hold_r_q <= axis.s_axis_data;
          full_q   <= 1'b1;
          ready_q  <= 1'b0;
        end else begin
          hold_l_q <= axis.s_axis_data;
        end
      end
    end
  end

  assign axis.s_axis_ready = ready_q;
  assign tx_mclk           = cnt_q[0];
  assign tx_sclk           = cnt_q[3];
  assign tx_lrck           = cnt_q[9];
  assign tx_sdout          = sdout_q;
  assign underrun          = underrun_q;

endmodule

// File: tb/tb_axis_i2s_transmitter.sv
// Scoreboard bench for axis_i2s_transmitter: captures whole I2S frames and compares them to expectations.
module tb_axis_i2s_transmitter;

  localparam int unsigned DW = 12;
`ifdef AXIS_I2S_TX_UNDERRUN_REPEAT_EN
  localparam bit Repeat = 1'b1;
`else
  localparam bit Repeat = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] left;
    logic [DW-1:0] right;
    int            ur;
    int            ur_off;
    int            zbad;
    bit            skip;
  } frame_t;

  logic       clk;
  logic       resetn;
  logic       tx_mclk;
  logic       tx_sclk;
  logic       tx_lrck;
  logic       tx_sdout;
  logic       underrun;
  logic [9:0] tb_cnt;

  int     checks;
  int     failures;
  int     bad_edges;
  frame_t got_q[$];
  frame_t exp_q[$];

  axis_i2s_transmitter_if #(.DATA_WIDTH(DW)) axis_bus ();

  axis_i2s_transmitter #(.DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .axis     (axis_bus),
    .tx_mclk  (tx_mclk),
    .tx_sclk  (tx_sclk),
    .tx_lrck  (tx_lrck),
    .tx_sdout (tx_sdout),
    .underrun (underrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference frame counter: free-running from reset release.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) tb_cnt <= 10'd0;
    else         tb_cnt <= tb_cnt + 10'd1;
  end

  // Frame monitor: samples tx_sdout on the SCLK-high midpoint and records one entry per frame.
  initial begin : monitor
    frame_t     cur;
    bit         in_frame;
    logic       prev_sd;
    logic [4:0] b;
    in_frame  = 1'b0;
    prev_sd   = 1'b0;
    bad_edges = 0;
    cur       = '{default: 0};
    forever begin
      @(negedge clk);
      if (!resetn) begin
        in_frame = 1'b0;
        prev_sd  = 1'b0;
      end else begin
        if (tx_sdout !== prev_sd && tb_cnt[3:0] != 4'd0) bad_edges++;
        prev_sd = tx_sdout;
        if (tb_cnt == 10'd0) begin
          in_frame = 1'b1;
          cur      = '{default: 0};
        end
        if (in_frame) begin
          if (underrun === 1'b1) begin
            if (tb_cnt == 10'd0) cur.ur++;
            else                 cur.ur_off++;
          end
          if (tb_cnt[3:0] == 4'd8) begin
            b = tb_cnt[8:4];
            if (b >= 5'd1 && 32'(b) <= DW) begin
              if (tb_cnt[9]) cur.right = {cur.right[DW-2:0], tx_sdout};
              else           cur.left  = {cur.left[DW-2:0], tx_sdout};
            end else if (tx_sdout !== 1'b0) begin
              cur.zbad++;
            end
          end
          if (tb_cnt == 10'd1023) begin
            got_q.push_back(cur);
            in_frame = 1'b0;
          end
        end
      end
    end
  end

  function automatic frame_t mk(input logic [DW-1:0] l, input logic [DW-1:0] r, input int ur,
                                input bit skip);
    frame_t f;
    f = '{default: 0};
    f.left  = l;
    f.right = r;
    f.ur    = ur;
    f.skip  = skip;
    return f;
  endfunction

  task automatic wait_cnt(input logic [9:0] v);
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      if (tb_cnt == v) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_cnt got=timeout required=%0d", v);
  endtask

  task automatic get_frame(output frame_t f, output bit ok);
    ok = 1'b0;
    f  = '{default: 0};
    for (int i = 0; i < 2200; i++) begin
      if (got_q.size() != 0) begin
        f  = got_q.pop_front();
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  // Drives one word and holds it until accepted; now=1 drives in the current timestep.
  task automatic send_word(input logic [DW-1:0] d, input logic l, input bit now);
    bit ok;
    ok = 1'b0;
    if (!now) @(negedge clk);
    axis_bus.s_axis_data  = d;
    axis_bus.s_axis_last  = l;
    axis_bus.s_axis_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (axis_bus.s_axis_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 axis_bus.s_axis_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_word got=not_accepted required=accepted data=%h", d);
    end
  endtask

  task automatic test_reset();
    resetn                = 1'b0;
    axis_bus.s_axis_data  = '0;
    axis_bus.s_axis_valid = 1'b0;
    axis_bus.s_axis_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (axis_bus.s_axis_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got=%b required=0", axis_bus.s_axis_ready);
    end
    checks++;
    if ({tx_mclk, tx_sclk, tx_lrck} !== 3'b000) begin
      failures++;
      $display("FAIL reset_clocks got=%b required=000", {tx_mclk, tx_sclk, tx_lrck});
    end
    checks++;
    if ({tx_sdout, underrun} !== 2'b00) begin
      failures++;
      $display("FAIL reset_sdout_underrun got=%b required=00", {tx_sdout, underrun});
    end
    resetn = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (axis_bus.s_axis_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%b required=1", axis_bus.s_axis_ready);
    end
    checks++;
    if (tx_mclk !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_mclk got=%b required=1", tx_mclk);
    end
  endtask

  task automatic test_basic();
    frame_t e;
    frame_t g;
    bit     ok;
    exp_q.push_back(mk(12'h000, 12'h000, 0, 1'b0));
    send_word(12'hABC, 1'b0, 1'b0);
    send_word(12'h123, 1'b1, 1'b0);
    exp_q.push_back(mk(12'hABC, 12'h123, 0, 1'b0));
    checks++;
    if (axis_bus.s_axis_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_ready_after_last got=%b required=0", axis_bus.s_axis_ready);
    end
    wait_cnt(10'd0);
    checks++;
    if (axis_bus.s_axis_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_ready_at_load got=%b required=0", axis_bus.s_axis_ready);
    end
    @(negedge clk);
    checks++;
    if (axis_bus.s_axis_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_ready_after_load got=%b required=1", axis_bus.s_axis_ready);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      get_frame(g, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL basic_frame got=timeout required=frame");
      end else begin
        checks++;
        if (g.left !== e.left || g.right !== e.right) begin
          failures++;
          $display("FAIL basic_data got=%h/%h required=%h/%h", g.left, g.right, e.left, e.right);
        end
        checks++;
        if (g.ur != e.ur || g.ur_off != 0 || g.zbad != 0) begin
          failures++;
          $display("FAIL basic_underrun_pad got=ur%0d off%0d pad%0d required=ur%0d off0 pad0",
                   g.ur, g.ur_off, g.zbad, e.ur);
        end
      end
    end
  endtask

  task automatic test_underrun();
    frame_t e;
    frame_t g;
    bit     ok;
    repeat (3) exp_q.push_back(mk(Repeat ? 12'hABC : 12'h000, Repeat ? 12'h123 : 12'h000, 1, 1'b0));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      get_frame(g, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL underrun_frame got=timeout required=frame");
      end else begin
        checks++;
        if (g.left !== e.left || g.right !== e.right) begin
          failures++;
          $display("FAIL underrun_data got=%h/%h required=%h/%h", g.left, g.right, e.left, e.right);
        end
        checks++;
        if (g.ur != e.ur || g.ur_off != 0 || g.zbad != 0) begin
          failures++;
          $display("FAIL underrun_pulse got=ur%0d off%0d pad%0d required=ur%0d off0 pad0",
                   g.ur, g.ur_off, g.zbad, e.ur);
        end
      end
    end
  endtask

  task automatic test_resync();
    frame_t e;
    frame_t g;
    bit     ok;
    wait_cnt(10'd10);
    got_q.delete();
    exp_q.push_back(mk(12'h000, 12'h000, 0, 1'b1));
    send_word(12'h111, 1'b0, 1'b0);
    send_word(12'h7FF, 1'b0, 1'b0);
    send_word(12'h800, 1'b1, 1'b0);
    exp_q.push_back(mk(12'h7FF, 12'h800, 0, 1'b0));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      get_frame(g, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL resync_frame got=timeout required=frame");
      end else if (!e.skip) begin
        checks++;
        if (g.left !== e.left || g.right !== e.right) begin
          failures++;
          $display("FAIL resync_data got=%h/%h required=%h/%h", g.left, g.right, e.left, e.right);
        end
        checks++;
        if (g.ur != e.ur || g.ur_off != 0 || g.zbad != 0) begin
          failures++;
          $display("FAIL resync_underrun_pad got=ur%0d off%0d pad%0d required=ur%0d off0 pad0",
                   g.ur, g.ur_off, g.zbad, e.ur);
        end
      end
    end
  endtask

  task automatic test_frame_edge();
    frame_t e;
    frame_t g;
    bit     ok;
    wait_cnt(10'd100);
    got_q.delete();
    exp_q.push_back(mk(12'h000, 12'h000, 0, 1'b1));
    send_word(12'h5A5, 1'b0, 1'b0);
    wait_cnt(10'd1023);
    checks++;
    if (axis_bus.s_axis_ready !== 1'b1) begin
      failures++;
      $display("FAIL edge_ready_before got=%b required=1", axis_bus.s_axis_ready);
    end
    send_word(12'h3C3, 1'b1, 1'b1);
    checks++;
    if (axis_bus.s_axis_ready !== 1'b0) begin
      failures++;
      $display("FAIL edge_ready_after got=%b required=0", axis_bus.s_axis_ready);
    end
    exp_q.push_back(mk(Repeat ? 12'h7FF : 12'h000, Repeat ? 12'h800 : 12'h000, 1, 1'b0));
    exp_q.push_back(mk(12'h5A5, 12'h3C3, 0, 1'b0));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      get_frame(g, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL edge_frame got=timeout required=frame");
      end else if (!e.skip) begin
        checks++;
        if (g.left !== e.left || g.right !== e.right) begin
          failures++;
          $display("FAIL edge_data got=%h/%h required=%h/%h", g.left, g.right, e.left, e.right);
        end
        checks++;
        if (g.ur != e.ur || g.ur_off != 0 || g.zbad != 0) begin
          failures++;
          $display("FAIL edge_underrun_pad got=ur%0d off%0d pad%0d required=ur%0d off0 pad0",
                   g.ur, g.ur_off, g.zbad, e.ur);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    frame_t e;
    frame_t g;
    bit     ok;
    wait_cnt(10'd100);
    send_word(12'h246, 1'b0, 1'b0);
    send_word(12'h9AB, 1'b1, 1'b0);
    wait_cnt(10'd600);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({tx_mclk, tx_sclk, tx_lrck, tx_sdout, underrun, axis_bus.s_axis_ready} !== 6'b0) begin
      failures++;
      $display("FAIL midreset_outputs got=%b required=000000",
               {tx_mclk, tx_sclk, tx_lrck, tx_sdout, underrun, axis_bus.s_axis_ready});
    end
    repeat (4) @(posedge clk);
    got_q.delete();
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (axis_bus.s_axis_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_ready got=%b required=1", axis_bus.s_axis_ready);
    end
    exp_q.push_back(mk(12'h000, 12'h000, 0, 1'b0));
    exp_q.push_back(mk(12'h000, 12'h000, 1, 1'b0));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      get_frame(g, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL midreset_frame got=timeout required=frame");
      end else begin
        checks++;
        if (g.left !== e.left || g.right !== e.right) begin
          failures++;
          $display("FAIL midreset_data got=%h/%h required=%h/%h", g.left, g.right, e.left, e.right);
        end
        checks++;
        if (g.ur != e.ur || g.ur_off != 0 || g.zbad != 0) begin
          failures++;
          $display("FAIL midreset_underrun_pad got=ur%0d off%0d pad%0d required=ur%0d off0 pad0",
                   g.ur, g.ur_off, g.zbad, e.ur);
        end
      end
    end
  endtask

  task automatic test_clocks();
    int e_m;
    int e_s;
    int e_l;
    e_m = 0;
    e_s = 0;
    e_l = 0;
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      if (tx_mclk !== tb_cnt[0]) e_m++;
      if (tx_sclk !== tb_cnt[3]) e_s++;
      if (tx_lrck !== tb_cnt[9]) e_l++;
    end
    checks++;
    if (e_m != 0) begin
      failures++;
      $display("FAIL clk_mclk got=%0d_bad_cycles required=0", e_m);
    end
    checks++;
    if (e_s != 0) begin
      failures++;
      $display("FAIL clk_sclk got=%0d_bad_cycles required=0", e_s);
    end
    checks++;
    if (e_l != 0) begin
      failures++;
      $display("FAIL clk_lrck got=%0d_bad_cycles required=0", e_l);
    end
    checks++;
    if (bad_edges != 0) begin
      failures++;
      $display("FAIL sdout_edges got=%0d required=0", bad_edges);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_underrun();
    test_resync();
    test_frame_edge();
    test_reset_mid();
    test_clocks();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
